// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 init, KSA and PRGA stages.
package rc4_pkg;

    localparam int S_SIZE   = 256;
    localparam int S_ADDR_W = 8;

    typedef logic [7:0] byte_t;

    // Every S access is split into drive-address / wait / capture states
    // because the single-port S memory returns q one clock after the address.
    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        WAIT_SI,
        LATCH_SI,
        WAIT_SJ,
        LATCH_SJ,
        WR_I,
        WR_J,
        RD_F,
        WAIT_F,
        LATCH_F,
        OUTPUT,
        FINISH
    } prga_state_t;

endpackage

// File: rtl/rc4_prga_reader.sv
// RC4 keystream generator (PRGA) driving the shared single-port S memory.
// Define RC4_CT_XOR_EN to emit plaintext (keystream XOR ct_in) instead of raw keystream.
module rc4_prga_reader
    import rc4_pkg::*;
#(
    parameter int MSG_LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [MSG_LEN_W-1:0]  msg_len,
    output logic [S_ADDR_W-1:0]   address,
    output byte_t                 data,
    output logic                  write_enable,
    input  byte_t                 q,
    input  byte_t                 ct_in,
    output byte_t                 ks_byte,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  busy,
    output logic                  done
);

    prga_state_t state;
    prga_state_t next_state;

    byte_t                i;
    byte_t                j;
    byte_t                si;
    byte_t                sj;
    logic [MSG_LEN_W-1:0] k;
    logic [MSG_LEN_W-1:0] msg_len_q;
    logic [MSG_LEN_W-1:0] k_inc;

    assign k_inc = k + MSG_LEN_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start && (msg_len != '0)) next_state = INC_I;
            INC_I:    next_state = WAIT_SI;
            WAIT_SI:  next_state = LATCH_SI;
            LATCH_SI: next_state = WAIT_SJ;
            WAIT_SJ:  next_state = LATCH_SJ;
            LATCH_SJ: next_state = WR_I;
            WR_I:     next_state = WR_J;
            WR_J:     next_state = RD_F;
            RD_F:     next_state = WAIT_F;
            WAIT_F:   next_state = LATCH_F;
            LATCH_F:  next_state = OUTPUT;
            OUTPUT: begin
                if (ks_valid && ks_ready) begin
                    next_state = (k_inc == msg_len_q) ? FINISH : INC_I;
                end
            end
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Memory port and datapath registers; WR_I then WR_J performs the swap, so
    // when i==j the later write of si leaves S unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i            <= '0;
            j            <= '0;
            si           <= '0;
            sj           <= '0;
            k            <= '0;
            msg_len_q    <= '0;
            address      <= '0;
            data         <= '0;
            write_enable <= 1'b0;
            ks_byte      <= '0;
            ks_valid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (msg_len != '0) begin
                            i         <= '0;
                            j         <= '0;
                            k         <= '0;
                            msg_len_q <= msg_len;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                INC_I: begin
                    i       <= i + 8'd1;
                    address <= i + 8'd1;
                end
                LATCH_SI: begin
                    si      <= q;
                    j       <= j + q;
                    address <= j + q;
                end
                LATCH_SJ: begin
                    sj <= q;
                end
                WR_I: begin
                    address      <= i;
                    data         <= sj;
                    write_enable <= 1'b1;
                end
                WR_J: begin
                    address      <= j;
                    data         <= si;
                    write_enable <= 1'b1;
                end
                RD_F: begin
                    write_enable <= 1'b0;
                    address      <= si + sj;
                end
                LATCH_F: begin
`ifdef RC4_CT_XOR_EN
                    ks_byte <= q ^ ct_in;
`else
                    ks_byte <= q;
`endif
                    ks_valid <= 1'b1;
                end
                OUTPUT: begin
                    if (ks_valid && ks_ready) begin
                        k        <= k_inc;
                        ks_valid <= 1'b0;
                        if (k_inc == msg_len_q) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef RC4_CT_XOR_EN
    logic unused_ct;
    assign unused_ct = ^ct_in;
`endif

endmodule

// File: tb/tb_rc4_prga_reader.sv
// Scoreboard bench for rc4_prga_reader against a plain RC4 PRGA reference model.
module tb_rc4_prga_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic [7:0] msg_len;
    logic [7:0] address;
    logic [7:0] data;
    logic       write_enable;
    logic [7:0] q = 8'h00;
    logic [7:0] ct_in;
    logic [7:0] ks_byte;
    logic       ks_valid;
    logic       ks_ready;
    logic       busy;
    logic       done;

    logic [7:0] mem     [256];
    logic [7:0] s_model [256];
    logic [7:0] ct_buf  [256];
    logic [7:0] exp_q   [$];

    int errors     = 0;
    int checks     = 0;
    int acc_total  = 0;
    int done_total = 0;
    int we_total   = 0;
    int run_base   = 0;
    int base_done  = 0;
    int base_we    = 0;
    bit rnd_ready  = 1'b0;

    logic [7:0] kat_ks [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] kat_ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] kat_pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] key    [3] = '{8'h4B, 8'h65, 8'h79};
    logic [7:0] id_ks  [3] = '{8'h02, 8'h05, 8'h07};

    assign ct_in = ct_buf[8'(acc_total - run_base)];

    rc4_prga_reader #(.MSG_LEN_W(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .msg_len      (msg_len),
        .address      (address),
        .data         (data),
        .write_enable (write_enable),
        .q            (q),
        .ct_in        (ct_in),
        .ks_byte      (ks_byte),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name, input int budget);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not seen, expected within %0d cycles", name, budget);
    endtask

    task automatic ram_model();
        forever begin
            @(posedge clk);
            if (write_enable) mem[address] <= data;
            q <= mem[address];
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) ks_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (write_enable) we_total++;
            if (done) begin
                done_total++;
                checkOutput("done_busy", 32'(busy), 32'd0);
            end
            if (ks_valid && ks_ready) begin
                acc_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no output", ks_byte);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ks_byte", 32'(ks_byte), 32'(e));
                end
            end
        end
    endtask

    // Reference RC4 PRGA over s_model, starting from i=j=0.
    task automatic model_run(input int n, input bit push);
        int i = 0;
        int j = 0;
        int t;
        logic [7:0] tmp;
        logic [7:0] e;
        for (int b = 0; b < n; b++) begin
            i = (i + 1) % 256;
            j = (j + int'(s_model[i])) % 256;
            tmp = s_model[i];
            s_model[i] = s_model[j];
            s_model[j] = tmp;
            t = (int'(s_model[i]) + int'(s_model[j])) % 256;
            e = s_model[t];
`ifdef RC4_CT_XOR_EN
            e = e ^ ct_buf[b];
`endif
            if (push) exp_q.push_back(e);
        end
    endtask

    task automatic load_s(input int mode);
        int b;
        logic [7:0] tmp;
        int j = 0;
        for (int a = 0; a < 256; a++) s_model[a] = 8'(a);
        if (mode == 1) begin
            for (int a = 255; a > 0; a--) begin
                b = $urandom_range(0, a);
                tmp = s_model[a]; s_model[a] = s_model[b]; s_model[b] = tmp;
            end
        end else if (mode == 2) begin
            for (int a = 0; a < 256; a++) begin
                j = (j + int'(s_model[a]) + int'(key[a % 3])) % 256;
                tmp = s_model[a]; s_model[a] = s_model[j]; s_model[j] = tmp;
            end
        end
        for (int a = 0; a < 256; a++) mem[a] = s_model[a];
    endtask

    task automatic check_s_array();
        int bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== s_model[a]) bad++;
        checkOutput("s_array_diffs", 32'(bad), 32'd0);
    endtask

    task automatic applyStimulus(input int n);
        base_done = done_total;
        base_we   = we_total;
        run_base  = acc_total;
        @(posedge clk);
        #1;
        start   = 1'b1;
        msg_len = 8'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_run(input int n);
        bit seen = 1'b0;
        int budget = n * 60 + 100;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            if (done_total != base_done) seen = 1'b1;
        end
        if (!seen) report_timeout("done_timeout", budget);
        repeat (3) @(posedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("done_count", 32'(done_total - base_done), 32'd1);
        checkOutput("we_cycles", 32'(we_total - base_we), 32'(2 * n));
        check_s_array();
        exp_q.delete();
    endtask

    initial begin
        int n;
        bit found;
        bit stable;
        int we_snap;
        logic [7:0] held;

        reset_n  = 1'b0;
        start    = 1'b0;
        msg_len  = 8'd0;
        ks_ready = 1'b1;
        for (int a = 0; a < 256; a++) ct_buf[a] = 8'h00;
        load_s(0);
        fork
            ram_model();
            monitor();
            ready_driver();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_address", 32'(address), 32'd0);
        checkOutput("rst_we", 32'(write_enable), 32'd0);
        checkOutput("rst_valid", 32'(ks_valid), 32'd0);
        checkOutput("rst_busy_done", {30'd0, busy, done}, 32'd0);
        checkOutput("rst_ks_data", {16'd0, ks_byte, data}, 32'd0);
        reset_n = 1'b1;

        $display("[TB] identity S, msg_len=3");
        load_s(0);
        model_run(3, 1'b0);
        for (int b = 0; b < 3; b++) exp_q.push_back(id_ks[b] ^ ct_buf[b]);
        applyStimulus(3);
        finish_run(3);
        checkOutput("s2", 32'(mem[2]), 32'd3);
        checkOutput("s3", 32'(mem[3]), 32'd5);
        checkOutput("s5", 32'(mem[5]), 32'd2);

        $display("[TB] KSA(\"Key\") S, msg_len=9");
        load_s(2);
        for (int b = 0; b < 9; b++) ct_buf[b] = kat_ct[b];
        model_run(9, 1'b0);
`ifdef RC4_CT_XOR_EN
        for (int b = 0; b < 9; b++) exp_q.push_back(kat_pt[b]);
`else
        for (int b = 0; b < 9; b++) exp_q.push_back(kat_ks[b]);
`endif
        applyStimulus(9);
        finish_run(9);

        $display("[TB] backpressure stall on byte 2");
        load_s(0);
        model_run(4, 1'b1);
        applyStimulus(4);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk);
            if (acc_total - run_base >= 1) found = 1'b1;
        end
        if (!found) report_timeout("stall_first_byte", 200);
        #1;
        ks_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (ks_valid) found = 1'b1;
        end
        if (!found) report_timeout("stall_second_valid", 200);
        held    = ks_byte;
        we_snap = we_total;
        stable  = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(ks_valid === 1'b1 && ks_byte === held && write_enable === 1'b0)) stable = 1'b0;
        end
        checkOutput("stall_hold", 32'(stable), 32'd1);
        checkOutput("stall_no_write", 32'(we_total - we_snap), 32'd0);
        @(posedge clk);
        #1;
        ks_ready = 1'b1;
        finish_run(4);

        $display("[TB] msg_len=0");
        applyStimulus(0);
        @(negedge clk);
        checkOutput("zero_len_done", 32'(done), 32'd1);
        repeat (5) @(posedge clk);
        checkOutput("zero_len_no_write", 32'(we_total - base_we), 32'd0);
        checkOutput("zero_len_done_count", 32'(done_total - base_done), 32'd1);
        checkOutput("zero_len_busy", 32'(busy), 32'd0);

        $display("[TB] start while busy");
        model_run(3, 1'b1);
        applyStimulus(3);
        repeat (5) @(posedge clk);
        #1;
        start   = 1'b1;
        msg_len = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_run(3);

        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            load_s(1);
            for (int b = 0; b < 256; b++) ct_buf[b] = 8'($urandom);
            n = $urandom_range(1, 16);
            rnd_ready = 1'b1;
            model_run(n, 1'b1);
            applyStimulus(n);
            finish_run(n);
            rnd_ready = 1'b0;
            #1;
            ks_ready = 1'b1;
        end

        $display("[TB] reset during WR_J");
        load_s(1);
        model_run(5, 1'b1);
        applyStimulus(5);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (write_enable) found = 1'b1;
        end
        if (!found) report_timeout("abort_wr_j", 100);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_address", 32'(address), 32'd0);
        checkOutput("abort_we", 32'(write_enable), 32'd0);
        checkOutput("abort_busy_valid_done", {29'd0, busy, ks_valid, done}, 32'd0);
        checkOutput("abort_ks_data", {16'd0, ks_byte, data}, 32'd0);
        exp_q.delete();
        for (int a = 0; a < 256; a++) s_model[a] = mem[a];
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_run(6, 1'b1);
        applyStimulus(6);
        finish_run(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
